// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for one single-ported unified memory
module mem_port_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_re,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rdy,
  input  logic        hlt,
  output logic        halted,
  output logic        err
);

  localparam int CW = (STARVE_MAX < 3) ? 2 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACC_I, ACC_D, HALT} state_t;

  state_t        state;
  logic [CW-1:0] starve;
  logic          d_req;
  logic          if_win;

  assign d_req  = d_re | d_we;
  // IF normally loses to data, unless it has watched STARVE_MAX data grants go by
  assign if_win = if_req & (~d_req | (starve == STARVE_LIM));

  assign if_stall = if_req & ~if_valid & (state != HALT);
  assign d_stall  = d_req & ~d_valid & (state != HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      starve    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (d_re && d_we) err <= 1'b1;

      case (state)
        IDLE: begin
          if (!if_req) starve <= '0;
          if (hlt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (if_win) begin
            state    <= ACC_I;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            starve   <= '0;
          end else if (d_req) begin
            // a simultaneous read+write is carried out as the write
            state     <= ACC_D;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (if_req && (starve != STARVE_LIM)) starve <= starve + CW'(1);
          end
        end
        ACC_I: begin
          if (mem_rdy) begin
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
            mem_en   <= 1'b0;
            state    <= IDLE;
          end
        end
        ACC_D: begin
          if (mem_rdy) begin
            if (!mem_we) d_rdata <= mem_rdata;
            d_valid <= 1'b1;
            mem_en  <= 1'b0;
            state   <= IDLE;
          end
        end
        HALT: begin
          mem_en <= 1'b0;
          halted <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
